// File: rtl/chi_nf_pkg.sv
// Shared constants and helpers for the two-share, no-fresh-randomness Chi pipeline.
package chi_nf_pkg;

  localparam int unsigned ROW_W      = 5;
  localparam int unsigned NUM_CF     = 20;
  localparam int unsigned CF_PER_BIT = 4;

  localparam int unsigned A = 4;
  localparam int unsigned B = 3;
  localparam int unsigned C = 2;
  localparam int unsigned D = 1;
  localparam int unsigned E = 0;

  // Unshared Chi on one row, used as a reference outside the datapath.
  function automatic logic [ROW_W-1:0] chi_ref(input logic [ROW_W-1:0] x);
    logic [ROW_W-1:0] y;
    y[A] = x[A] ^ (~x[B] & x[C]);
    y[B] = x[B] ^ (~x[C] & x[D]);
    y[C] = x[C] ^ (~x[D] & x[E]);
    y[D] = x[D] ^ (~x[E] & x[A]);
    y[E] = x[E] ^ (~x[A] & x[B]);
    return y;
  endfunction

  // Component function num: output bit i = num/4 uses x=v[i], y=v[i+1], z=v[i+2];
  // each CF touches exactly one share of every variable it reads.
  function automatic logic nf_cf(input int unsigned num,
                                 input logic [ROW_W-1:0] s1,
                                 input logic [ROW_W-1:0] s2);
    int unsigned i;
    logic [2:0]  xi;
    logic [2:0]  yi;
    logic [2:0]  zi;
    logic        r;
    i  = num / CF_PER_BIT;
    xi = 3'(ROW_W - 1 - i);
    yi = 3'(ROW_W - 1 - ((i + 1) % ROW_W));
    zi = 3'(ROW_W - 1 - ((i + 2) % ROW_W));
    case (num % CF_PER_BIT)
      0:       r = s1[xi] ^ (~s1[yi] & s1[zi]);
      1:       r = ~s1[yi] & s2[zi];
      2:       r = s2[xi] ^ (s2[yi] & s1[zi]);
      default: r = s2[yi] & s2[zi];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/chi_nf_row.sv
// One Chi row: 20 component functions over the two input shares, registered
// as a glitch barrier that only loads on an accepted input beat.
module chi_nf_row
  import chi_nf_pkg::*;
(
  input  logic              clk,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [ROW_W-1:0]  s1_i,
  input  logic [ROW_W-1:0]  s2_i,
  output logic [NUM_CF-1:0] cf_o
);

  logic [NUM_CF-1:0] cf_new;
  logic [NUM_CF-1:0] cf_d;
  logic [NUM_CF-1:0] cf_q;

  for (genvar k = 0; k < NUM_CF; k++) begin : g_cf
    assign cf_new[k] = nf_cf(k, s1_i, s2_i);
  end

  always_comb begin
    cf_d = cf_q;
    if (en_i) cf_d = cf_new;
  end

  always_ff @(posedge clk) begin
    if (rst_i) cf_q <= '0;
    else       cf_q <= cf_d;
  end

  assign cf_o = cf_q;

endmodule

// File: rtl/chi_nofresh_pipe.sv
// Handshaked two-share Chi pipeline: registered component functions, registered
// share compression, and a beat counter framing one Keccak state.
module chi_nofresh_pipe
  import chi_nf_pkg::*;
#(
  parameter int unsigned ROWS  = 5,
  parameter int unsigned BEATS = 64
) (
  input  logic                    clk,
  input  logic                    rst_i,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ROW_W*ROWS-1:0]   in1,
  input  logic [ROW_W*ROWS-1:0]   in2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ROW_W*ROWS-1:0]   out1,
  output logic [ROW_W*ROWS-1:0]   out2,
  output logic                    out_last,
  output logic                    busy
);

  localparam int unsigned W     = ROW_W * ROWS;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic              in_fire_c;
  logic              s2_load_c;
  logic              out_fire_c;

  logic [NUM_CF-1:0] row_cf [ROWS];
  logic [W-1:0]      cmp1_c;
  logic [W-1:0]      cmp2_c;

  logic              s1_valid_d,  s1_valid_q;
  logic              out_valid_d, out_valid_q;
  logic              out_last_d,  out_last_q;
  logic [W-1:0]      out1_d,      out1_q;
  logic [W-1:0]      out2_d,      out2_q;
  logic [CNT_W-1:0]  cnt_d,       cnt_q;

  assign in_ready   = ~s1_valid_q | ~out_valid_q | out_ready;
  assign in_fire_c  = in_valid & in_ready;
  assign s2_load_c  = s1_valid_q & (~out_valid_q | out_ready);
  assign out_fire_c = out_valid_q & out_ready;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    chi_nf_row u_row (
      .clk   (clk),
      .rst_i (rst_i),
      .en_i  (in_fire_c),
      .s1_i  (in1[ROW_W*r +: ROW_W]),
      .s2_i  (in2[ROW_W*r +: ROW_W]),
      .cf_o  (row_cf[r])
    );
  end

  // Compression reads only the stage-1 registers; output bit i lands at row bit 4-i.
  always_comb begin
    cmp1_c = '0;
    cmp2_c = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned i = 0; i < ROW_W; i++) begin
        cmp1_c[ROW_W*r + ROW_W-1-i] = row_cf[r][CF_PER_BIT*i]     ^ row_cf[r][CF_PER_BIT*i + 1];
        cmp2_c[ROW_W*r + ROW_W-1-i] = row_cf[r][CF_PER_BIT*i + 2] ^ row_cf[r][CF_PER_BIT*i + 3];
      end
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    out1_d      = out1_q;
    out2_d      = out2_q;
    cnt_d       = cnt_q;

    if (in_fire_c)      s1_valid_d = 1'b1;
    else if (s2_load_c) s1_valid_d = 1'b0;

    if (s2_load_c) begin
      out_valid_d = 1'b1;
      out1_d      = cmp1_c;
      out2_d      = cmp2_c;
    end else if (out_fire_c) begin
      out_valid_d = 1'b0;
    end

    if (out_fire_c) cnt_d = (cnt_q == CNT_W'(BEATS - 1)) ? '0 : cnt_q + CNT_W'(1);

    out_last_d = out_valid_d & (cnt_d == CNT_W'(BEATS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out1_q      <= '0;
      out2_q      <= '0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out1_q      <= out1_d;
      out2_q      <= out2_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out1      = out1_q;
  assign out2      = out2_q;
  assign busy      = s1_valid_q | out_valid_q;

endmodule

// File: tb/tb_chi_nofresh_pipe.sv
// Bench for chi_nofresh_pipe: directed steps plus random traffic against a
// queue-based model of the unshared Chi function and the two-deep pipeline.
module tb_chi_nofresh_pipe;
  import chi_nf_pkg::*;

  localparam int unsigned ROWS  = 5;
  localparam int unsigned BEATS = 64;
  localparam int unsigned W     = 5 * ROWS;

  logic         clk;
  logic         rst_i;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out1;
  logic [W-1:0] out2;
  logic         out_last;
  logic         busy;

  chi_nofresh_pipe #(.ROWS(ROWS), .BEATS(BEATS)) u_dut (
    .clk       (clk),
    .rst_i     (rst_i),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out1      (out1),
    .out2      (out2),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned  total = 0;
  int unsigned  bad   = 0;

  logic [W-1:0] exp_q [$];
  int unsigned  acc_q [$];
  int unsigned  edge_n   = 0;
  int unsigned  last_pop = 0;
  int unsigned  pops     = 0;
  int unsigned  vld_seen = 0;
  int unsigned  last_seen = 0;
  logic         stall_chk = 1'b0;
  logic [W-1:0] s_o1, s_o2;
  logic         s_last;

  // Chi written directly from the row equations: v[0..4] = a..e.
  function automatic logic [4:0] chi5(input logic [4:0] x);
    logic v [5];
    logic [4:0] y;
    for (int j = 0; j < 5; j++) v[j] = x[4-j];
    for (int i = 0; i < 5; i++) y[4-i] = v[i] ^ (~v[(i+1)%5] & v[(i+2)%5]);
    return y;
  endfunction

  function automatic logic [W-1:0] chi_plane(input logic [W-1:0] x);
    logic [W-1:0] y;
    for (int r = 0; r < ROWS; r++) y[5*r +: 5] = chi5(x[5*r +: 5]);
    return y;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv)
      else begin
        bad++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic r);
    in_valid  = v;
    in1       = a;
    in2       = b;
    out_ready = r;
  endtask

  function automatic logic [W-1:0] rnd();
    return W'($urandom);
  endfunction

  // One clock: check outputs against the model, then advance model and DUT together.
  task automatic tick();
    logic exp_vld, exp_rdy, in_fire, out_fire;
    int unsigned vis, e;
    #1;
    exp_vld = 1'b0;
    if (exp_q.size() > 0) begin
      vis = (acc_q[0] + 1 > last_pop) ? acc_q[0] + 1 : last_pop;
      exp_vld = (edge_n >= vis);
    end
    exp_rdy = (exp_q.size() < 2) || out_ready;
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    check("out_valid", 64'(out_valid), 64'(exp_vld));
    check("busy", 64'(busy), 64'(exp_q.size() > 0));
    check("out_last", 64'(out_last), 64'(exp_vld && ((pops % BEATS) == BEATS - 1)));
    if (exp_vld) check("data", 64'(out1 ^ out2), 64'(exp_q[0]));
    if (stall_chk) begin
      check("hold_out1", 64'(out1), 64'(s_o1));
      check("hold_out2", 64'(out2), 64'(s_o2));
      check("hold_last", 64'(out_last), 64'(s_last));
    end
    if (out_valid) vld_seen++;
    if (out_last)  last_seen++;
    out_fire  = exp_vld && out_ready;
    in_fire   = in_valid && exp_rdy;
    stall_chk = exp_vld && !out_ready;
    s_o1 = out1; s_o2 = out2; s_last = out_last;
    e = edge_n + 1;
    if (out_fire) begin
      void'(exp_q.pop_front());
      void'(acc_q.pop_front());
      pops++;
      last_pop = e;
    end
    if (in_fire) begin
      exp_q.push_back(chi_plane(in1 ^ in2));
      acc_q.push_back(e);
    end
    @(posedge clk);
    edge_n = e;
    #1;
  endtask

  task automatic do_reset();
    rst_i    = 1'b1;
    in_valid = 1'($urandom);
    @(posedge clk);
    edge_n++;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_out_last", 64'(out_last), 64'(0));
    check("rst_out1", 64'(out1), 64'(0));
    check("rst_out2", 64'(out2), 64'(0));
    exp_q.delete();
    acc_q.delete();
    pops      = 0;
    last_pop  = edge_n;
    stall_chk = 1'b0;
    rst_i     = 1'b0;
    drive(1'b0, '0, '0, 1'b1);
  endtask

  logic [4:0]   pat_in  [4] = '{5'h00, 5'h1F, 5'h10, 5'h01};
  logic [4:0]   pat_out [4] = '{5'h00, 5'h1F, 5'h12, 5'h05};
  logic [W-1:0] r1, want;
  logic [4:0]   px;

  initial begin
    drive(1'b0, '0, '0, 1'b1);
    do_reset();
    #1;
    check("rdy_after_rst", 64'(in_ready), 64'(1));

    for (int x = 0; x < 32; x++) check("chi_ref", 64'(chi_ref(5'(x))), 64'(chi5(5'(x))));

    // Single beat latency.
    drive(1'b1, W'(25'h0000001), '0, 1'b1);
    tick();
    drive(1'b0, rnd(), rnd(), 1'b1);
    tick();
    check("lat_valid", 64'(out_valid), 64'(1));
    check("lat_data", 64'(out1 ^ out2), 64'(25'h0000005));
    tick();

    // Fixed unshared patterns replicated in every row, random masks.
    for (int k = 0; k < 4; k++) begin
      r1 = rnd();
      px = pat_in[k];
      drive(1'b1, r1, r1 ^ {ROWS{px}}, 1'b1);
      tick();
      drive(1'b0, rnd(), rnd(), 1'b1);
      tick();
      px   = pat_out[k];
      want = {ROWS{px}};
      check("pattern", 64'(out1 ^ out2), 64'(want));
      tick();
    end

    // Fill, then stall with a continuous input stream.
    for (int i = 0; i < 5; i++) begin drive(1'b1, rnd(), rnd(), 1'b1); tick(); end
    for (int s = 0; s < 5; s++) begin
      drive(1'b1, rnd(), rnd(), 1'b0);
      #1;
      if (s >= 1) check("stall_rdy", 64'(in_ready), 64'(0));
      tick();
    end
    for (int i = 0; i < 5; i++) begin drive(1'b1, rnd(), rnd(), 1'b1); tick(); end
    for (int i = 0; i < 3; i++) begin drive(1'b0, rnd(), rnd(), 1'b1); tick(); end
    check("stall_drained", 64'(exp_q.size()), 64'(0));

    // Both stages held while idle inputs toggle.
    for (int i = 0; i < 2; i++) begin drive(1'b1, rnd(), rnd(), 1'b0); tick(); end
    s_o1 = out1;
    r1   = out2;
    for (int i = 0; i < 10; i++) begin drive(1'b0, rnd(), rnd(), 1'b0); tick(); end
    check("idle_out1", 64'(out1), 64'(s_o1));
    check("idle_out2", 64'(out2), 64'(r1));
    for (int i = 0; i < 3; i++) begin drive(1'b0, rnd(), rnd(), 1'b1); tick(); end

    // Random traffic.
    for (int i = 0; i < 10000; i++) begin
      drive($urandom_range(0, 3) != 0, rnd(), rnd(), $urandom_range(0, 3) != 0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin drive(1'b0, rnd(), rnd(), 1'b1); tick(); end

    // Full state back to back: 65 beats, one out_last.
    do_reset();
    vld_seen = 0; last_seen = 0;
    for (int i = 0; i < 65; i++) begin drive(1'b1, rnd(), rnd(), 1'b1); tick(); end
    for (int i = 0; i < 3; i++)  begin drive(1'b0, rnd(), rnd(), 1'b1); tick(); end
    check("b2b_valid_cycles", 64'(vld_seen), 64'(65));
    check("b2b_last_count", 64'(last_seen), 64'(1));

    // Reset with counter at 10 and two beats in flight.
    do_reset();
    for (int i = 0; i < 10; i++) begin drive(1'b1, rnd(), rnd(), 1'b1); tick(); end
    for (int i = 0; i < 2; i++)  begin drive(1'b0, rnd(), rnd(), 1'b1); tick(); end
    check("pre_rst_count", 64'(pops), 64'(10));
    for (int i = 0; i < 2; i++)  begin drive(1'b1, rnd(), rnd(), 1'b0); tick(); end
    check("pre_rst_busy", 64'(busy), 64'(1));
    do_reset();
    vld_seen = 0; last_seen = 0;
    for (int i = 0; i < 63; i++) begin drive(1'b1, rnd(), rnd(), 1'b1); tick(); end
    for (int i = 0; i < 2; i++)  begin drive(1'b0, rnd(), rnd(), 1'b1); tick(); end
    check("mid_rst_no_last", 64'(last_seen), 64'(0));
    drive(1'b1, rnd(), rnd(), 1'b1); tick();
    for (int i = 0; i < 3; i++)  begin drive(1'b0, rnd(), rnd(), 1'b1); tick(); end
    check("mid_rst_last", 64'(last_seen), 64'(1));
    check("mid_rst_beats", 64'(vld_seen), 64'(64));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chi_nofresh_pipe.md
# chi_nofresh_pipe

Parametrised, handshaked successor to the single-row two-share Chi cell of the no-fresh-randomness Keccak S-box. Each beat processes ROWS independent 5-bit Chi rows in two Boolean shares, with no fresh randomness. The component-function outputs are registered as a glitch barrier, then compressed into two output shares. Valid/ready flow control with backpressure allows the block to sit between the masked theta/rho/pi datapath and iota. A beat counter frames a full Keccak state.

## Interface
Parameters:
- ROWS, 5, Chi rows per beat (5 = one 25-bit plane); W = 5*ROWS.
- BEATS, 64, beats per Keccak state; sets out_last period (64 × 5 rows = 320 rows = 1600 bits).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in1  in  W  share 1; row r occupies bits [5r+4:5r], bit 4 = a … bit 0 = e.
- in2  in  W  share 2, same layout.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out1  out  W  output share 1, same row/bit layout as inputs.
- out2  out  W  output share 2.
- out_last  out  1  qualifies the final beat (index BEATS-1) of a state.
- busy  out  1  any pipeline stage holds a beat.

## Operation
- Per row, unshared function: out1^out2 = chi(in1^in2).
  - a' = a ^ (~b & c)
  - b' = b ^ (~c & d)
  - c' = c ^ (~d & e)
  - d' = d ^ (~e & a)
  - e' = e ^ (~a & b)
- Stage 1, per row: 20 component functions (index 0..19) over share pairs a..e, feeding a 20-bit register. Loads only on the input handshake (in_valid & in_ready). Holds otherwise, so no unsolicited share mixing.
- Stage 2, per row and output bit i (i = 0 → a' … 4 → e'):
  - share 1 = CF[4i] ^ CF[4i+1]
  - share 2 = CF[4i+2] ^ CF[4i+3]
  - Result is registered into out1/out2, at bit position 4-i of the row.
- No combinational path from in1/in2 to out1/out2. Compression XORs read only stage-1 registers.
- Beat counter (clog2(BEATS) bits) advances on each output handshake (out_valid & out_ready). Wraps BEATS-1 → 0. out_last = out_valid & (count == BEATS-1).
- busy = s1_valid | out_valid.

## Timing
- Reset (synchronous) clears:
  - s1_valid, out_valid, out_last, busy → 0
  - out1/out2 → 0, stage-1 registers → 0, beat counter → 0
- in_ready is combinational, never from in_valid: in_ready = ~s1_valid | ~out_valid | out_ready.
- Stage advance: s2_load = s1_valid & (~out_valid | out_ready). Stage 1 frees the same cycle it advances.
- Latency: 2 cycles from input handshake to out_valid with out_ready held high. Throughput: 1 beat/cycle.
- Stall: out_valid held with out_ready low keeps out1/out2/out_last stable. Stage 1 then fills once, and in_ready drops until out_ready returns.
- Simultaneous input handshake and stage-1 advance: stage 1 takes the new beat; no bubble.
- Reset mid-operation:
  - In-flight beats are discarded and the counter zeroes.
  - in_ready = 1 on the first cycle after rst_i deasserts.
- Counter wrap: the beat after the out_last beat has index 0. A reset is the only other way to return the counter to 0.

## Structure
- Package chi_nf_pkg:
  - ROW_W = 5, NUM_CF = 20, CF_PER_BIT = 4
  - row bit-index constants A..E
  - a chi_ref function for bench use
- Sub-module chi_nf_row: one row's 20 component-function instances (the team's NF_CF cell, num 0..19) plus the enable-gated 20-bit stage-1 register. Instantiated ROWS times by generate.
- The top holds the handshake logic, compression, output registers and beat counter.

## Test plan
- Reset, then one beat with ROWS=5, in1 = 25'h0000001, in2 = 0 (row 0 = 5'h01) → after 2 cycles out_valid = 1, row 0 of out1^out2 = 5'h05, other rows 0, in_ready high throughout.
- Per row, random 25-bit in1 with in2 = in1 ^ x for 5'h00 / 5'h1F / 5'h10 / 5'h01 → unshared rows 5'h00 / 5'h1F / 5'h12 / 5'h05. Also 10k random share pairs checked against chi_ref.
- 64 back-to-back beats with out_ready = 1 → 64 consecutive out_valid cycles, out_last only on beat 63; next beat has index 0 (out_last low).
- Hold out_ready = 0 for 5 cycles with a continuous input stream → in_ready = 0 from the second cycle on; out1/out2 stable. On release, beats exit in order with none lost or duplicated.
- Assert rst_i with 2 beats in flight and counter = 10 → out_valid = 0 and busy = 0 the next cycle; the following state's first beat has index 0 (out_last low), and out_last asserts only on the 64th output beat after reset.
- Idle cycles with toggling in1/in2 and in_valid = 0 → stage-1 registers and outputs unchanged, so no share recombination occurs.
